pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller. Drives the per-stage load enables (`*_en`, 1 = advance, 0 = hold) and the synchronous active-low clears (`*_clr_n`, 0 = insert bubble) into the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC.
- Resolves load-use hazards, a fixed-latency divider wait, fetch/data memory busy, and exception redirect, including discard of an in-flight fetch.

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Central pipeline controller for a five-stage pipeline. Produces the PC load
// enable, the PC redirect request and the per-stage load enables / synchronous
// active-low clears for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Resolves exception/ERET redirect (including discard of an in-flight fetch),
// data memory busy, a fixed-latency divider occupying EX, load-use hazards and
// instruction fetch busy, in that priority order.
//
// Parameters:
//   DIV_CYCLES   cycles EX is occupied by DIV/DIVU, counted from div_start (2..63)
//   EXC_VECTOR   PC loaded on a non-ERET exception
//
// Ports:
//   clk, rset                 clock, asynchronous active-low reset
//   ld_use_hazard             ID instruction depends on a load in EX
//   div_start                 one-cycle pulse, DIV/DIVU entered EX
//   if_busy                   fetch outstanding, IF output not valid
//   mem_busy                  data access outstanding in MEM
//   exc_req, exc_is_eret      MEM-stage exception / ERET request
//   exc_pc                    ERET target
//   pc_en, pc_redirect        PC load enable and redirect select
//   redirect_pc               redirect target
//   *_en, *_clr_n             stage register load enables and clears
//   stall_cycles              stall performance counter
//
// Configuration macro: PIPE_PERF_CNT_EN
//   defined   -> stall_cycles counts clocks with pc_en=0 (wrapping)
//   undefined -> stall_cycles is constant 0, no counter flops
module pipe_hazard_ctrl #(
    parameter int          DIV_CYCLES = 33,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rset,
    input  logic        ld_use_hazard,
    input  logic        div_start,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        exc_is_eret,
    output logic        pc_en,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_clr_n,
    output logic        id_ex_clr_n,
    output logic        ex_mem_clr_n,
    output logic        mem_wb_clr_n,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN,
        DIV_WAIT,
        DRAIN
    } state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state;
    logic [5:0] div_cnt;
    logic       ex_occupied;

    // The start cycle itself already occupies EX, before the state register
    // has moved to DIV_WAIT.
    assign ex_occupied = (state == DIV_WAIT) || ((state == RUN) && div_start);

    // Priority ladder; each stalled stage holds and feeds a bubble downstream.
    always_comb begin
        pc_en        = 1'b1;
        pc_redirect  = 1'b0;
        redirect_pc  = 32'h0;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_clr_n  = 1'b1;
        id_ex_clr_n  = 1'b1;
        ex_mem_clr_n = 1'b1;
        mem_wb_clr_n = 1'b1;
        if (!rset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_clr_n  = 1'b0;
            id_ex_clr_n  = 1'b0;
            ex_mem_clr_n = 1'b0;
            mem_wb_clr_n = 1'b0;
        end else if (exc_req) begin
            pc_redirect  = 1'b1;
            redirect_pc  = exc_is_eret ? exc_pc : EXC_VECTOR;
            if_id_clr_n  = 1'b0;
            id_ex_clr_n  = 1'b0;
            ex_mem_clr_n = 1'b0;
            mem_wb_clr_n = 1'b0;
        end else if (mem_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_clr_n = 1'b0;
        end else if (ex_occupied) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_clr_n = 1'b0;
        end else if (ld_use_hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_clr_n  = 1'b0;
        end else if (if_busy || (state == DRAIN)) begin
            pc_en        = 1'b0;
            if_id_clr_n  = 1'b0;
        end
    end

    // Controller state. The divider counts independently of memory stalls, so
    // the decrement is not gated by mem_busy. DRAIN ends on the first cycle
    // the stale fetch completes; that cycle is still cleared by the ladder.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state   <= RUN;
            div_cnt <= 6'd0;
        end else if (exc_req) begin
            div_cnt <= 6'd0;
            state   <= if_busy ? DRAIN : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (div_start) begin
                        div_cnt <= DIV_LOAD;
                        state   <= DIV_WAIT;
                    end
                end
                DIV_WAIT: begin
                    div_cnt <= div_cnt - 6'd1;
                    if (div_cnt == 6'd1) begin
                        state <= RUN;
                    end
                end
                DRAIN: begin
                    if (!if_busy) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state   <= RUN;
                    div_cnt <= 6'd0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_count;

    // Counts every clock on which the PC is held; wraps naturally.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            stall_count <= 32'h0;
        end else if (!pc_en) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign stall_cycles = stall_count;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// -------------------
// Scoreboard bench for pipe_hazard_ctrl. The driver applies one input vector
// per cycle, computes the expected outputs from a cycle-number based model
// and pushes them into a queue; the monitor pops and compares on the falling
// edge. Directed sequences are followed by randomized traffic.
module tb_pipe_hazard_ctrl;

    localparam int          DIV = 33;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rset = 1'b0;
    logic        ld_use_hazard = 1'b0;
    logic        div_start = 1'b0;
    logic        if_busy = 1'b0;
    logic        mem_busy = 1'b0;
    logic        exc_req = 1'b0;
    logic [31:0] exc_pc = 32'h0;
    logic        exc_is_eret = 1'b0;
    logic        pc_en, pc_redirect;
    logic [31:0] redirect_pc;
    logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n;
    logic [31:0] stall_cycles;

    pipe_hazard_ctrl #(
        .DIV_CYCLES(DIV),
        .EXC_VECTOR(VEC)
    ) dut (
        .clk(clk),
        .rset(rset),
        .ld_use_hazard(ld_use_hazard),
        .div_start(div_start),
        .if_busy(if_busy),
        .mem_busy(mem_busy),
        .exc_req(exc_req),
        .exc_pc(exc_pc),
        .exc_is_eret(exc_is_eret),
        .pc_en(pc_en),
        .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc),
        .if_id_en(if_id_en),
        .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en),
        .if_id_clr_n(if_id_clr_n),
        .id_ex_clr_n(id_ex_clr_n),
        .ex_mem_clr_n(ex_mem_clr_n),
        .mem_wb_clr_n(mem_wb_clr_n),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // ctl = {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //        if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n}
    typedef struct packed {
        logic [9:0]  ctl;
        logic [31:0] rpc;
        logic [31:0] stall;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    // Reference model: EX is busy until an absolute cycle number, the drain
    // condition is a flag, and the stall count is a plain integer.
    int          cyc = 0;
    int          div_release = 0;
    bit          draining = 1'b0;
    logic [31:0] perf = 32'h0;

    task automatic applyStimulus(input logic r, input logic ld, input logic ds,
                                 input logic ib, input logic mb, input logic ex,
                                 input logic [31:0] epc, input logic er);
        exp_t e;
        bit   div_busy;
        bit   in_run;
        @(posedge clk);
        #1;
        rset          = r;
        ld_use_hazard = ld;
        div_start     = ds;
        if_busy       = ib;
        mem_busy      = mb;
        exc_req       = ex;
        exc_pc        = epc;
        exc_is_eret   = er;

        div_busy = (cyc < div_release);
        in_run   = !div_busy && !draining;
        e.cyc    = cyc;
        e.rpc    = 32'h0;
        if (!r) begin
            div_release = 0;
            draining    = 1'b0;
            perf        = 32'h0;
            e.ctl       = 10'b00_0000_0000;
        end else begin
            e.ctl = 10'b10_1111_1111;
            if (ex) begin
                e.ctl = 10'b11_1111_0000;
                e.rpc = er ? epc : VEC;
            end else if (mb) begin
                e.ctl = 10'b00_0001_1110;
            end else if (div_busy || (in_run && ds)) begin
                e.ctl = 10'b00_0011_1101;
            end else if (ld) begin
                e.ctl = 10'b00_0111_1011;
            end else if (ib || draining) begin
                e.ctl = 10'b00_1111_0111;
            end
        end
`ifdef PIPE_PERF_CNT_EN
        e.stall = perf;
`else
        e.stall = 32'h0;
`endif
        sb.push_back(e);

        if (r) begin
            if (ex) begin
                div_release = 0;
                draining    = ib;
            end else if (in_run && ds) begin
                div_release = cyc + DIV;
            end else if (draining && !ib) begin
                draining = 1'b0;
            end
            if (!e.ctl[9]) perf = perf + 32'd1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [9:0] got;
        got = {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_clr_n, id_ex_clr_n, ex_mem_clr_n, mem_wb_clr_n};
        tests++;
        if (got !== e.ctl) begin
            fails++;
            $display("[TB] FAIL ctl cycle %0d: got %b expected %b", e.cyc, got, e.ctl);
        end
        tests++;
        if (redirect_pc !== e.rpc) begin
            fails++;
            $display("[TB] FAIL redirect_pc cycle %0d: got %h expected %h", e.cyc, redirect_pc, e.rpc);
        end
        tests++;
        if (stall_cycles !== e.stall) begin
            fails++;
            $display("[TB] FAIL stall_cycles cycle %0d: got %h expected %h", e.cyc, stall_cycles, e.stall);
        end
    endtask

    // Monitor: compares whatever the driver has scheduled for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int          wait_cnt;
        logic        r, ld, ds, ib, mb, ex, er;
        logic [31:0] epc;

        // Reset then clean release.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
        idle(3);

        // Single load-use hazard.
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0, 0);
        idle(2);

        // Divider alone, then with a memory stall in the middle of the wait.
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h0, 0);
        idle(40);
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h0, 0);
        idle(10);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, 0, 32'h0, 0);
        idle(25);

        // Exception during the divider wait with a fetch still outstanding.
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h0, 0);
        idle(5);
        applyStimulus(1, 0, 0, 1, 0, 1, 32'h0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, 0, 32'h0, 0);
        idle(3);

        // ERET while memory is busy.
        applyStimulus(1, 0, 0, 0, 1, 1, 32'h80001234, 1);
        idle(2);

        // Reset in the middle of a divider wait and of a drain.
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h0, 0);
        idle(4);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
        idle(2);
        applyStimulus(1, 0, 0, 1, 0, 1, 32'h0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
        idle(2);

        // Fetch busy for ten cycles.
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1, 0, 0, 32'h0, 0);
        idle(2);

`ifdef PIPE_PERF_CNT_EN
        // Preload the counter just below wrap and stall across the boundary.
        @(negedge clk);
        #1;
        force dut.stall_count = 32'hFFFFFFFE;
        #1;
        release dut.stall_count;
        perf = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, 0, 32'h0, 0);
        idle(2);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom % 500) != 0;
            ld  = ($urandom % 8) == 0;
            ds  = ($urandom % 40) == 0;
            ib  = ($urandom % 4) == 0;
            mb  = ($urandom % 6) == 0;
            ex  = ($urandom % 60) == 0;
            er  = $urandom % 2;
            epc = $urandom;
            applyStimulus(r, ld, ds, ib, mb, ex, epc, er);
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain scoreboard: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
